mmu_sched: RTL
==============

Name: mmu_sched

Overview:
- Shares one page-table walker (translate unit) and one memory bus port between two requesters: instruction fetch (I, port 0) and data access (D, port 1).
- For each granted request it runs three phases in order:
  - lets the walker translate the VA, routing walker PTE reads onto the bus;
  - performs the real access at the resulting PA;
  - returns a one-cycle response to the winner.
- Sits between the fetch/memory pipeline stages and the core's single memory interface.

Parameters:
- FAIR, 1, 1 = round-robin between I and D on simultaneous requests; 0 = fixed priority to D.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request; held with i_va stable until i_ok
- i_va  in  64  fetch virtual address
- i_ok  out  1  one-cycle response strobe to I
- i_err  out  1  valid with i_ok; 1 = translation fault
- d_req  in  1  data request; held with d_va/d_we/d_wdata/d_size stable until d_ok
- d_va  in  64  data virtual address
- d_we  in  1  1 = store
- d_wdata  in  64  store data
- d_size  in  3  access size code, passed to bus
- d_ok  out  1  one-cycle response strobe to D
- d_err  out  1  valid with d_ok; translation fault
- rdata  out  64  load/fetch data, valid with i_ok/d_ok
- tr_en  out  1  walker enable
- tr_va  out  64  VA to walker
- tr_done  in  1  walker finished (may be combinational, same cycle as tr_en)
- tr_valid  in  1  translation valid, qualified by tr_done
- tr_pa  in  64  translated PA, qualified by tr_done
- tr_mem_req  in  1  walker PTE read request
- tr_mem_addr  in  64  walker PTE address
- tr_pte  out  64  PTE data to walker (= mrdata)
- tr_pte_valid  out  1  PTE data valid (= mresp_valid while in WALK)
- mreq  out  1  bus request
- maddr  out  64  bus address
- mwe  out  1  bus write enable
- mwdata  out  64  bus write data
- msize  out  3  bus size
- mresp_valid  in  1  bus response; sampled only while mreq=1
- mrdata  in  64  bus read data

Behaviour:
- Reset (async, immediate):
  - state=IDLE; last_grant=D, so I wins the first tie when FAIR=1.
  - Outputs 0: i_ok, d_ok, i_err, d_err, rdata, tr_en, mreq, mwe, maddr, mwdata, msize.
  - A bus or walker transaction in flight is abandoned; no response is issued.
- IDLE:
  - tr_en=0, mreq=0.
  - If any req is high, grant one and latch va/we/wdata/size; go WALK.
  - Both high, FAIR=1: grant the port not in last_grant. FAIR=0: grant D.
  - last_grant updates on grant.
- WALK:
  - tr_en=1, tr_va=latched va.
  - Bus driven by walker: mreq=tr_mem_req, maddr=tr_mem_addr, mwe=0, msize=3'b011.
  - tr_pte=mrdata; tr_pte_valid=mresp_valid & tr_mem_req.
  - On tr_done: latch tr_pa and tr_valid. tr_valid=1 → ACCESS; tr_valid=0 → RESP with err=1 and rdata=0.
  - If tr_done coincides with a PTE response (leaf found), the bus beat counts as complete.
- ACCESS:
  - tr_en=1 (walker parks in DONE).
  - mreq=1, maddr=latched PA, mwe/mwdata/msize from latched request (I: mwe=0, msize=3'b011).
  - Hold until mresp_valid, then latch mrdata into rdata and go RESP.
- RESP:
  - Pulse ok/err to the granted port for exactly one cycle.
  - tr_en=0, which returns the walker to IDLE; mreq=0; next state IDLE.
  - A new grant is possible in the following cycle; the requester may hold req high to issue back-to-back.
- No request is granted outside IDLE. A req dropped before ok is a protocol violation (undefined).
- Other inputs:
  - tr_done outside WALK is ignored.
  - mresp_valid with mreq=0 is ignored.
- Latency (bare translation, bus answering in its first request cycle): req seen in cycle 0 (IDLE), ok in cycle 3.
- Only the granted port's ok/err may be 1; rdata holds its value until the next RESP.

Test Plan:
- Bare walker (tr_done=1 combinational, tr_pa=tr_va), i_req va=0x8000_0000, bus responds in 1st cycle with 0x13 → mreq cycle 2 at 0x8000_0000, i_ok cycle 3, rdata=0x13, i_err=0.
- Sv39 walk: walker issues 3 PTE reads at 0x1000/0x2008/0x3010, each answered after 2 cycles, then PA 0x8765_4321; d_req store 0xDEAD → bus sees 3 reads (mwe=0), then a write at 0x8765_4321 with mwdata=0xDEAD; d_ok once.
- i_req and d_req asserted in the same cycle after reset, FAIR=1 → I served first, then D. Repeat with both held → alternates I,D,I,D. With FAIR=0 → D always first.
- tr_valid=0 on tr_done → no ACCESS beat (mreq stays 0), d_ok=1 with d_err=1, rdata=0.
- Reset asserted mid-ACCESS, asynchronously → mreq, tr_en and ok drop before the next clock edge; after release, a new request completes normally.
- Bus holds mresp_valid=0 for 10 cycles in ACCESS → maddr/mreq stable throughout, no ok until the response arrives.

Source files
------------

// File: rtl/mmu_sched.sv
// rtl/mmu_sched.sv - shares one page-table walker and one bus port between fetch and data requesters
module mmu_sched #(
  parameter int FAIR = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [63:0] i_va,
  output logic        i_ok,
  output logic        i_err,
  input  logic        d_req,
  input  logic [63:0] d_va,
  input  logic        d_we,
  input  logic [63:0] d_wdata,
  input  logic [2:0]  d_size,
  output logic        d_ok,
  output logic        d_err,
  output logic [63:0] rdata,
  output logic        tr_en,
  output logic [63:0] tr_va,
  input  logic        tr_done,
  input  logic        tr_valid,
  input  logic [63:0] tr_pa,
  input  logic        tr_mem_req,
  input  logic [63:0] tr_mem_addr,
  output logic [63:0] tr_pte,
  output logic        tr_pte_valid,
  output logic        mreq,
  output logic [63:0] maddr,
  output logic        mwe,
  output logic [63:0] mwdata,
  output logic [2:0]  msize,
  input  logic        mresp_valid,
  input  logic [63:0] mrdata
);

  typedef enum logic [1:0] {IDLE, WALK, ACCESS, RESP} state_t;

  state_t      state;
  logic        gnt_d;
  logic        last_d;
  logic        we_q;
  logic [63:0] va_q;
  logic [63:0] pa_q;
  logic [63:0] wdata_q;
  logic [2:0]  size_q;
  logic        pick_d;

  // D wins when alone, under fixed priority, or when I was the previous grant.
  always_comb begin
    pick_d = d_req && (!i_req || (FAIR == 0) || !last_d);
  end

  // Scheduler: grant in IDLE, translate, access, then one-cycle registered response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      gnt_d   <= 1'b0;
      last_d  <= 1'b1;
      we_q    <= 1'b0;
      va_q    <= '0;
      pa_q    <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      i_ok    <= 1'b0;
      d_ok    <= 1'b0;
      i_err   <= 1'b0;
      d_err   <= 1'b0;
      rdata   <= '0;
    end else begin
      i_ok  <= 1'b0;
      d_ok  <= 1'b0;
      i_err <= 1'b0;
      d_err <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            gnt_d   <= pick_d;
            last_d  <= pick_d;
            va_q    <= pick_d ? d_va : i_va;
            we_q    <= pick_d && d_we;
            wdata_q <= pick_d ? d_wdata : 64'd0;
            size_q  <= pick_d ? d_size : 3'b011;
            state   <= WALK;
          end
        end
        WALK: begin
          if (tr_done) begin
            pa_q <= tr_pa;
            if (tr_valid) begin
              state <= ACCESS;
            end else begin
              rdata <= '0;
              i_ok  <= !gnt_d;
              d_ok  <= gnt_d;
              i_err <= !gnt_d;
              d_err <= gnt_d;
              state <= RESP;
            end
          end
        end
        ACCESS: begin
          if (mresp_valid) begin
            rdata <= mrdata;
            i_ok  <= !gnt_d;
            d_ok  <= gnt_d;
            state <= RESP;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Bus steering: walker owns the bus during WALK, the latched request during ACCESS.
  always_comb begin
    tr_en        = 1'b0;
    tr_pte_valid = 1'b0;
    mreq         = 1'b0;
    maddr        = '0;
    mwe          = 1'b0;
    mwdata       = '0;
    msize        = '0;
    case (state)
      WALK: begin
        tr_en        = 1'b1;
        mreq         = tr_mem_req;
        maddr        = tr_mem_addr;
        msize        = 3'b011;
        tr_pte_valid = mresp_valid && tr_mem_req;
      end
      ACCESS: begin
        tr_en  = 1'b1;
        mreq   = 1'b1;
        maddr  = pa_q;
        mwe    = we_q;
        mwdata = wdata_q;
        msize  = size_q;
      end
      default: begin
      end
    endcase
  end

  assign tr_va  = va_q;
  assign tr_pte = mrdata;

endmodule
